// File: rtl/fetch_ctrl.sv
// Fetch sequencer: holds the PC through boot, then selects the next PC from
// flush, redirect or sequential sources, deferring flushes that arrive under stall.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        flush_req,
  input  logic [31:0] flush_target,
  input  logic [31:0] PCPlus4_F,
  output logic [31:0] Nextpc,
  output logic        PC_WrEn,
  output logic        FD_En,
  output logic        FD_Clr,
  output logic [31:0] fetch_cnt,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] ST_BOOT       = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_FLUSH_PEND = 2'd2;
  localparam logic [3:0] BOOT_LAST     = 4'(BOOT_CYCLES - 32'd1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] nextpc_s;
  logic        pc_wr_s;
  logic        fd_en_s;
  logic        fd_clr_s;

  // Next-state and control decode; a flush seen under stall is parked in pend_q.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pend_d     = pend_q;
    nextpc_s   = RESET_PC;
    pc_wr_s    = 1'b0;
    fd_en_s    = 1'b0;
    fd_clr_s   = 1'b1;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_RUN: begin
        fd_clr_s = 1'b0;
        nextpc_s = PCPlus4_F;
        if (!stall) begin
          pc_wr_s = 1'b1;
          fd_en_s = 1'b1;
          if (flush_req) begin
            nextpc_s = flush_target;
            fd_clr_s = 1'b1;
          end else if (redir_valid) begin
            nextpc_s = redir_target;
          end else begin
            nextpc_s = PCPlus4_F;
          end
        end else if (flush_req) begin
          pend_d  = flush_target;
          state_d = ST_FLUSH_PEND;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH_PEND: begin
        nextpc_s = pend_q;
        if (stall) begin
          fd_clr_s = 1'b0;
          if (flush_req) begin
            pend_d = flush_target;
          end else begin
            pend_d = pend_q;
          end
        end else begin
          pc_wr_s  = 1'b1;
          fd_en_s  = 1'b1;
          fd_clr_s = 1'b1;
          state_d  = ST_RUN;
          if (flush_req) begin
            nextpc_s = flush_target;
          end else begin
            nextpc_s = pend_q;
          end
        end
      end
      default: begin
        state_d    = ST_BOOT;
        boot_cnt_d = 4'd0;
      end
    endcase
  end

  // Activity counters: fetch count wraps, stall count saturates and ignores boot.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, pc_wr_s};
    if ((state_q == ST_RUN || state_q == ST_FLUSH_PEND) && !pc_wr_s &&
        (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, boot counter, pending target and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 4'd0;
      pend_q      <= 32'd0;
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_q      <= pend_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset gating keeps outputs at boot values the instant reset asserts.
  assign Nextpc    = reset ? nextpc_s : RESET_PC;
  assign PC_WrEn   = reset ? pc_wr_s  : 1'b0;
  assign FD_En     = reset ? fd_en_s  : 1'b0;
  assign FD_Clr    = reset ? fd_clr_s : 1'b1;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule
